// File: rtl/piece_rng_pkg.sv
// piece_rng_pkg: constants and types shared by the piece generator and the spawn logic.
//   TapsDefault  - Galois feedback mask for x^16+x^14+x^13+x^11+1
//   SeedDefault  - non-zero reset / fallback LFSR seed
//   NPieces      - number of distinct pieces in the standard set
//   piece_t      - piece index type for the standard set
//   state_e      - generator FSM states
package piece_rng_pkg;

  localparam logic [15:0] TapsDefault = 16'hB400;
  localparam logic [15:0] SeedDefault = 16'hACE1;
  localparam int unsigned NPieces     = 7;
  localparam int unsigned PieceW      = $clog2(NPieces);

  typedef logic [PieceW-1:0] piece_t;

  typedef enum logic [0:0] {
    StDraw,
    StPresent
  } state_e;

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR with an entropy bit folded into the MSB.
//   clka     - clock, state updates on posedge
//   step     - advance one position this cycle
//   load     - load load_val (takes priority over step)
//   load_val - value to load; zero is replaced by SEED_DEFAULT
//   entropy  - bit XORed into the MSB on each step
//   state    - current register value
// An all-zero state is never stored: both the load path and the step path
// substitute SEED_DEFAULT so the register cannot lock up.
module lfsr_galois
  import piece_rng_pkg::*;
#(
  parameter int unsigned        LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]  TAPS         = TapsDefault,
  parameter logic [LFSR_W-1:0]  SEED_DEFAULT = SeedDefault
) (
  input  logic              clka,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              entropy,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d, stepped;

  always_comb begin
    stepped = (state_q >> 1) ^ (state_q[0] ? TAPS : '0) ^ {entropy, {(LFSR_W-1){1'b0}}};
    state_d = state_q;
    if (load) begin
      state_d = (load_val == '0) ? SEED_DEFAULT : load_val;
    end else if (step) begin
      state_d = (stepped == '0) ? SEED_DEFAULT : stepped;
    end
  end

  // No reset of its own: the parent drives load with SEED_DEFAULT on restart.
  always_ff @(posedge clka) begin
    state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/piece_rng.sv
// piece_rng: rejection-sampled random piece index source with valid/ready output.
//   clka        - sole clock
//   restart     - synchronous active-high reset (beats seed_load and handshake)
//   seed_load   - pulse: reseed the LFSR and discard any presented piece
//   seed        - seed value (zero selects SEED_DEFAULT)
//   entropy     - synchronised user-input bit mixed into the LFSR
//   piece_ready - consumer accepts piece
//   piece_valid - piece holds a valid index
//   piece       - piece index 0..N_PIECES-1
// Optional: define PIECE_RNG_BAG_EN for bag mode, where every N_PIECES pieces
// from a bag boundary form a permutation. Default build is uniform sampling.
module piece_rng
  import piece_rng_pkg::*;
#(
  parameter int unsigned        N_PIECES     = NPieces,
  parameter int unsigned        PIECE_W      = $clog2(N_PIECES),
  parameter int unsigned        LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]  TAPS         = TapsDefault,
  parameter logic [LFSR_W-1:0]  SEED_DEFAULT = SeedDefault,
  parameter int unsigned        MAX_TRIES    = 8
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               entropy,
  input  logic               piece_ready,
  output logic               piece_valid,
  output logic [PIECE_W-1:0] piece
);

  localparam int unsigned       TryW    = ($clog2(MAX_TRIES) > 0) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TryW-1:0]   TryLast = TryW'(MAX_TRIES - 1);
  localparam logic [PIECE_W:0]  NLimit  = N_PIECES[PIECE_W:0];

  logic [LFSR_W-1:0]  lfsr;
  logic [PIECE_W-1:0] cand, pick;
  logic               in_range, cand_ok;

  state_e             state_q, state_d;
  logic [PIECE_W-1:0] piece_q, piece_d;
  logic               valid_q, valid_d;
  logic [TryW-1:0]    tries_q, tries_d;

  lfsr_galois #(
    .LFSR_W       (LFSR_W),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .clka     (clka),
    .step     (!(restart || seed_load)),
    .load     (restart || seed_load),
    .load_val (restart ? SEED_DEFAULT : seed),
    .entropy  (entropy),
    .state    (lfsr)
  );

  assign cand     = lfsr[PIECE_W-1:0];
  assign in_range = {1'b0, cand} < NLimit;

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[LFSR_W-1:PIECE_W];

`ifdef PIECE_RNG_BAG_EN
  logic [N_PIECES-1:0] bag_q, bag_d, bag_set, bag_next;
  logic                cand_used;
  logic [PIECE_W-1:0]  fallback;

  always_comb begin
    cand_used = 1'b0;
    fallback  = '0;
    // Descending scan leaves the lowest unused index in fallback.
    for (int i = int'(N_PIECES) - 1; i >= 0; i--) begin
      if (!bag_q[i]) fallback = PIECE_W'(i);
    end
    for (int i = 0; i < int'(N_PIECES); i++) begin
      if (cand == PIECE_W'(i)) cand_used = bag_q[i];
    end
    cand_ok = in_range && !cand_used;
    pick    = cand_ok ? cand : fallback;
    bag_set = bag_q;
    for (int i = 0; i < int'(N_PIECES); i++) begin
      if (pick == PIECE_W'(i)) bag_set[i] = 1'b1;
    end
    // A completed bag empties on the same edge as its last accept.
    bag_next = (&bag_set) ? '0 : bag_set;
  end
`else
  always_comb begin
    cand_ok = in_range;
    pick    = cand_ok ? cand : '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    piece_d = piece_q;
    valid_d = valid_q;
    tries_d = tries_q;
`ifdef PIECE_RNG_BAG_EN
    bag_d   = bag_q;
`endif
    unique case (state_q)
      StDraw: begin
        if (cand_ok || (tries_q == TryLast)) begin
          piece_d = pick;
          valid_d = 1'b1;
          tries_d = '0;
          state_d = StPresent;
`ifdef PIECE_RNG_BAG_EN
          bag_d   = bag_next;
`endif
        end else begin
          tries_d = tries_q + TryW'(1);
        end
      end
      StPresent: begin
        if (valid_q && piece_ready) begin
          valid_d = 1'b0;
          state_d = StDraw;
        end
      end
      default: state_d = StDraw;
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q <= StDraw;
      piece_q <= '0;
      valid_q <= 1'b0;
      tries_q <= '0;
`ifdef PIECE_RNG_BAG_EN
      bag_q   <= '0;
`endif
    end else if (seed_load) begin
      // piece keeps its value; only the valid flag withdraws it.
      state_q <= StDraw;
      valid_q <= 1'b0;
      tries_q <= '0;
`ifdef PIECE_RNG_BAG_EN
      bag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      piece_q <= piece_d;
      valid_q <= valid_d;
      tries_q <= tries_d;
`ifdef PIECE_RNG_BAG_EN
      bag_q   <= bag_d;
`endif
    end
  end

  assign piece_valid = valid_q;
  assign piece       = piece_q;

endmodule

// File: tb/tb_piece_rng.sv
// tb_piece_rng: scoreboard bench for piece_rng. Directed expected pieces are
// queued by the stimulus process and popped by a monitor on each handshake.
// With PIECE_RNG_BAG_EN defined the directed uniform sequences are skipped
// and the random phase checks bag permutations instead.
module tb_piece_rng;

  localparam int unsigned N  = 7;
  localparam int unsigned MT = 8;
`ifdef PIECE_RNG_BAG_EN
  localparam int unsigned RandPieces = 700;
`else
  localparam int unsigned RandPieces = 10000;
`endif

  logic        clka = 1'b0;
  logic        restart = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = '0;
  logic        entropy = 1'b0;
  logic        piece_ready = 1'b0;
  logic        piece_valid;
  logic [2:0]  piece;

  always #5 clka = ~clka;

  piece_rng dut (
    .clka        (clka),
    .restart     (restart),
    .seed_load   (seed_load),
    .seed        (seed),
    .entropy     (entropy),
    .piece_ready (piece_ready),
    .piece_valid (piece_valid),
    .piece       (piece)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned exp_q[$];
  bit          prop_mode = 1'b0;
  bit          bag_clr = 1'b0;
  int          hs_count = 0;
  int          since_hs = 0;
  int          low_run = 0;
  bit          seen_hs = 1'b0;
  bit [7:0]    seen_mask = '0;
  int          in_bag = 0;

  function automatic void check(input string name, input int unsigned act,
                                input int unsigned req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: handshakes are qualified away from restart/seed_load edges.
  always @(negedge clka) begin
    if (bag_clr) begin
      seen_mask = '0;
      in_bag    = 0;
      bag_clr   = 1'b0;
    end
    if (piece_valid && piece_ready && !restart && !seed_load) begin
      if (prop_mode) begin
        check("piece_range", piece < N, 1);
        if (seen_hs) check("handshake_spacing", since_hs >= 1, 1);
`ifdef PIECE_RNG_BAG_EN
        check("bag_unique", seen_mask[piece], 0);
        seen_mask[piece] = 1'b1;
        in_bag++;
        if (in_bag == int'(N)) begin
          check("bag_complete", seen_mask, 8'h7f);
          seen_mask = '0;
          in_bag    = 0;
        end
`endif
      end else if (exp_q.size() == 0) begin
        check("unexpected_handshake", exp_q.size(), 1);
      end else begin
        check("piece", piece, exp_q.pop_front());
      end
      hs_count++;
      since_hs = 0;
      seen_hs  = 1'b1;
    end else begin
      since_hs++;
    end
    if (prop_mode) begin
      if (!piece_valid) begin
        low_run++;
      end else begin
        if (low_run > 0) check("valid_gap", low_run <= int'(MT) + 1, 1);
        low_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Pieces after SEED_DEFAULT (16'hACE1) with entropy=0 and ready held high.
  task automatic push_default_seq();
    int unsigned seq[8] = '{1, 0, 6, 3, 4, 1, 4, 3};
    foreach (seq[i]) exp_q.push_back(seq[i]);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!piece_valid && n < int'(MT) + 1) begin
      tick();
      n++;
    end
    check(name, piece_valid, 1);
  endtask

  initial begin
    int lat;
    int start;
    int cyc;
    tick();

`ifndef PIECE_RNG_BAG_EN
    // Reset state, first-piece latency and hold while not ready.
    restart = 1'b1;
    tick();
    check("reset_valid", piece_valid, 0);
    check("reset_piece", piece, 0);
    restart = 1'b0;
    lat = 0;
    while (!piece_valid && lat < int'(MT) + 1) begin
      tick();
      lat++;
    end
    check("first_valid", piece_valid, 1);
    check("first_latency", lat, 1);
    check("first_piece", piece, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_valid", piece_valid, 1);
      check("hold_piece", piece, 1);
    end
    exp_q.push_back(1);
    piece_ready = 1'b1;
    tick();
    piece_ready = 1'b0;
    wait_drain("held_accept", 4);

    // Back-to-back stream from restart.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    push_default_seq();
    piece_ready = 1'b1;
    wait_drain("restart_stream", 60);
    piece_ready = 1'b0;

    // seed=1: accept on first DRAW, LFSR at 16'hB400 gives 0,0,0 next.
    seed = 16'h0001;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed1_cleared", piece_valid, 0);
    tick();
    check("seed1_valid", piece_valid, 1);
    check("seed1_piece", piece, 1);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    piece_ready = 1'b1;
    wait_drain("seed1_stream", 30);
    piece_ready = 1'b0;

    // seed=7: cand 7 rejected, then 16'hB403 gives 3.
    seed = 16'h0007;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed7_cleared", piece_valid, 0);
    tick();
    check("seed7_reject", piece_valid, 0);
    tick();
    check("seed7_valid", piece_valid, 1);
    check("seed7_piece", piece, 3);
    exp_q.push_back(3);
    piece_ready = 1'b1;
    wait_drain("seed7_accept", 4);
    piece_ready = 1'b0;

    // seed=0 falls back to SEED_DEFAULT: same stream as after restart.
    seed = 16'h0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    push_default_seq();
    piece_ready = 1'b1;
    wait_drain("seed0_stream", 60);
    piece_ready = 1'b0;

    // restart and seed_load together while a piece is presented.
    wait_valid("pre_collide_valid");
    seed = 16'h0007;
    restart = 1'b1;
    seed_load = 1'b1;
    tick();
    check("collide_valid", piece_valid, 0);
    check("collide_piece", piece, 0);
    restart = 1'b0;
    seed_load = 1'b0;
    push_default_seq();
    piece_ready = 1'b1;
    wait_drain("collide_stream", 60);
    piece_ready = 1'b0;
`endif

    // Random entropy, ready held high; checked by properties only.
    restart = 1'b1;
    bag_clr = 1'b1;
    tick();
    restart = 1'b0;
    prop_mode = 1'b1;
    seen_hs = 1'b0;
    low_run = 0;
    piece_ready = 1'b1;
    start = hs_count;
    cyc = 0;
    while (hs_count - start < int'(RandPieces) && cyc < int'(RandPieces) * (int'(MT) + 2)) begin
      entropy = 1'($urandom);
`ifdef PIECE_RNG_BAG_EN
      // Reseed mid-bag once; the bag must restart from empty.
      if (hs_count - start == 353 && !seed_load && cyc > 0) begin
        seed = 16'($urandom);
        seed_load = 1'b1;
        bag_clr = 1'b1;
        tick();
        seed_load = 1'b0;
        start = start - 1;
      end
`endif
      tick();
      cyc++;
    end
    check("random_run_done", hs_count - start >= int'(RandPieces), 1);
    prop_mode = 1'b0;
    piece_ready = 1'b0;
    entropy = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
